// File: rtl/etc_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the ETC tile accumulation path.
// Latency: n/a (types only).
// Backpressure: n/a.
package etc_pkg;

    // Element width of the extended tensor core datapath.
    localparam int ETC_W = 16;

    // Reduction select: zero is the MMA path (wrapping add); any other value is MAXMUL.
    localparam logic [1:0] ETC_OP_MMA = 2'd0;

    // One 4x4 tile laid out exactly as the ETC drives it: [row][col][bit].
    typedef logic [3:0][3:0][ETC_W-1:0] etc_tile_t;

    // Accumulator control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } etc_state_e;

    // True when the op selects the additive semiring.
    function automatic logic etc_op_is_mma(input logic [1:0] op);
        return (op == ETC_OP_MMA);
    endfunction

endpackage

// File: rtl/etc_tile_accum_elem_reduce.sv
`timescale 1ns/1ps
// Single-element semiring reduction: wrapping add for MMA, unsigned max otherwise.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module etc_elem_reduce
    import etc_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_in,
    input  logic [1:0]   i_op,
    output logic [W-1:0] o_res
);

    logic [W-1:0] w_sum;
    logic [W-1:0] w_max;

    // The carry out of the sum is dropped on purpose: MMA accumulates modulo 2^W.
    assign w_sum = i_acc + i_in;
    assign w_max = (i_acc > i_in) ? i_acc : i_in;

    // Pick the reduction for this element.
    always_comb begin
        o_res = w_max;
        if (etc_op_is_mma(i_op)) begin
            o_res = w_sum;
        end
    end

endmodule

// File: rtl/etc_tile_accum.sv
`timescale 1ns/1ps
// Folds a stream of 4x4 ETC partial tiles into one tile per group (add or max).
// Latency: out_valid rises the cycle after the in_last tile is accepted.
// Backpressure: in_ready drops while a finished tile waits for out_ready.
module etc_tile_accum
    import etc_pkg::*;
#(
    parameter int W     = 16,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [1:0]              in_op,
    input  logic [3:0][3:0][W-1:0]  in_tile,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0][3:0][W-1:0]  out_tile,
    output logic [1:0]              out_op,
    output logic [CNT_W-1:0]        out_count,
    output logic                    err_op
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    etc_state_e               r_state;
    logic [3:0][3:0][W-1:0]   r_acc;
    logic [1:0]               r_op;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_err;

    logic                     w_in_xfer;
    logic                     w_out_xfer;
    logic [3:0][3:0][W-1:0]   w_red;
    logic [CNT_W-1:0]         w_cnt_next;

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // The group op is fixed by its first tile, so every element reduces with r_op.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            etc_elem_reduce #(
                .W (W)
            ) u_reduce (
                .i_acc (r_acc[gi][gj]),
                .i_in  (in_tile[gi][gj]),
                .i_op  (r_op),
                .o_res (w_red[gi][gj])
            );
        end
    end

    // Tile counter sticks at its maximum; accumulation itself keeps going.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_cnt != CNT_MAX) begin
            w_cnt_next = r_cnt + CNT_ONE;
        end
    end

    // Group state machine, accumulator, counter and sticky op-mismatch flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        r_acc   <= in_tile;
                        r_op    <= in_op;
                        r_cnt   <= CNT_ONE;
                        r_state <= in_last ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_in_xfer) begin
                        r_acc <= w_red;
                        r_cnt <= w_cnt_next;
                        if (in_op != r_op) begin
                            r_err <= 1'b1;
                        end
                        if (in_last) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // No bypass into a new group: the next tile is taken from IDLE.
                    if (w_out_xfer) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_tile  = r_acc;
    assign out_op    = r_op;
    assign out_count = r_cnt;
    assign err_op    = r_err;

endmodule

// File: tb/tb_etc_tile_accum.sv
`timescale 1ns/1ps
// Directed bench for etc_tile_accum: add/max folding, wrap, hold, op mismatch, reset, saturation.
// Latency: checks out_valid the cycle after the last accepted tile.
// Backpressure: exercises out_ready held low while in_valid is driven.
module tb_etc_tile_accum;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [1:0]             in_op;
    logic [3:0][3:0][15:0]  in_tile;
    logic                   out_valid;
    logic                   out_ready;
    logic [3:0][3:0][15:0]  out_tile;
    logic [1:0]             out_op;
    logic [7:0]             out_count;
    logic                   err_op;

    int checks = 0;
    int errors = 0;

    etc_tile_accum #(
        .W     (16),
        .CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_tile   (in_tile),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tile  (out_tile),
        .out_op    (out_op),
        .out_count (out_count),
        .err_op    (err_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        logic [255:0] f;
        for (int i = 0; i < 16; i++) f[i*16 +: 16] = v;
        return f;
    endfunction

    // Present one tile and wait (bounded) for it to be accepted; returns 1 after-edge+1.
    task automatic send(input logic [255:0] t, input logic [1:0] op, input logic last);
        bit done;
        done     = 0;
        in_tile  = t;
        in_op    = op;
        in_last  = last;
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // Accept the finished tile and return to IDLE.
    task automatic drain();
        bit seen;
        seen = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (out_valid) seen = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) chk("drain_timeout", 0, 1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [255:0] t;
        logic [255:0] e;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_op     = 2'd0;
        in_tile   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_tile",  out_tile,  0);
        chk("rst_out_op",    out_op,    0);
        chk("rst_out_count", out_count, 0);
        chk("rst_err_op",    err_op,    0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Add group: 1 + 2 + 3 = 6.
        send(fill(16'd1), 2'd0, 1'b0);
        chk("add_no_early_valid", out_valid, 0);
        send(fill(16'd2), 2'd0, 1'b0);
        send(fill(16'd3), 2'd0, 1'b1);
        chk("add_valid",    out_valid, 1);
        chk("add_in_ready", in_ready,  0);
        chk("add_tile",     out_tile,  fill(16'd6));
        chk("add_count",    out_count, 3);
        chk("add_op",       out_op,    0);
        drain();
        chk("add_idle_valid", out_valid, 0);

        // Max group: [0][0] 5,9,2 -> 9; others FFFF,0,7 -> FFFF.
        t = fill(16'hFFFF); t[15:0] = 16'd5;
        send(t, 2'd1, 1'b0);
        t = fill(16'h0000); t[15:0] = 16'd9;
        send(t, 2'd1, 1'b0);
        t = fill(16'h0007); t[15:0] = 16'd2;
        send(t, 2'd1, 1'b1);
        e = fill(16'hFFFF); e[15:0] = 16'd9;
        chk("max_tile",  out_tile,  e);
        chk("max_count", out_count, 3);
        chk("max_op",    out_op,    1);
        drain();

        // Wrapping add: FFFF + 2 = 1.
        send(fill(16'hFFFF), 2'd0, 1'b0);
        send(fill(16'h0002), 2'd0, 1'b1);
        chk("wrap_tile",  out_tile,  fill(16'h0001));
        chk("wrap_count", out_count, 2);

        // Hold in DONE with out_ready low while a tile is offered.
        in_tile  = fill(16'h0055);
        in_op    = 2'd0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready",  in_ready,  0);
            chk("hold_out_valid", out_valid, 1);
            chk("hold_tile",      out_tile,  fill(16'h0001));
            chk("hold_count",     out_count, 2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();
        chk("post_hold_in_ready",  in_ready,  1);
        chk("post_hold_out_valid", out_valid, 0);
        send(fill(16'h1234), 2'd0, 1'b1);
        chk("post_hold_tile",  out_tile,  fill(16'h1234));
        chk("post_hold_count", out_count, 1);
        chk("pre_err_clear",   err_op,    0);
        drain();

        // Op mismatch on the second tile: add still used, flag sticks.
        send(fill(16'd10), 2'd0, 1'b0);
        send(fill(16'd20), 2'd2, 1'b1);
        chk("mm_tile",  out_tile, fill(16'd30));
        chk("mm_op",    out_op,   0);
        chk("mm_err",   err_op,   1);
        drain();
        send(fill(16'd3), 2'd1, 1'b1);
        chk("mm_next_tile", out_tile, fill(16'd3));
        chk("mm_next_op",   out_op,   1);
        chk("mm_err_stick", err_op,   1);
        drain();
        chk("mm_err_idle", err_op, 1);

        // Reset mid-group discards it and clears the flag.
        send(fill(16'd1), 2'd0, 1'b0);
        send(fill(16'd1), 2'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_ready", in_ready,  1);
        chk("mid_rst_err",   err_op,    0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("after_rst_valid", out_valid, 0);
        send(fill(16'd7), 2'd0, 1'b1);
        chk("after_rst_tile",  out_tile,  fill(16'd7));
        chk("after_rst_count", out_count, 1);
        chk("after_rst_op",    out_op,    0);
        drain();

        // 260 tiles of 1: count saturates at 255, sum keeps going to 260.
        for (int k = 0; k < 260; k++) send(fill(16'd1), 2'd0, (k == 259));
        chk("sat_count", out_count, 255);
        chk("sat_tile",  out_tile,  fill(16'd260));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/etc_tile_accum.md
# etc_tile_accum

Accumulates a stream of 4x4 partial-result tiles from the extended tensor core (`etcMaxMul`) across the K dimension. Tiles are combined element-wise with the semiring reduction selected by `op`: wrapping add for `op==0`, unsigned max for any other `op`. The block then emits one finished 4x4 tile per group over a valid/ready handshake. It sits directly downstream of the ETC's registered `out` and upstream of the tile writeback.

## Interface
Parameters:
- `W`, 16, element width; matches the ETC element width.
- `CNT_W`, 8, width of the tiles-per-group counter.

Ports:
- `clk`, in, 1, single clock; all state updates on the rising edge.
- `rst`, in, 1, synchronous, active-high reset.
- `in_valid`, in, 1, `in_tile` carries a valid partial tile.
- `in_ready`, out, 1, block can accept a tile this cycle.
- `in_last`, in, 1, this tile closes the current group.
- `in_op`, in, 2, reduction select; sampled on the first tile of a group.
- `in_tile`, in, [3:0][3:0][W-1:0], partial tile, same layout as the ETC output.
- `out_valid`, out, 1, `out_tile` holds a finished group.
- `out_ready`, in, 1, consumer accepts `out_tile`.
- `out_tile`, out, [3:0][3:0][W-1:0], accumulated tile.
- `out_op`, out, 2, op latched for the emitted group.
- `out_count`, out, CNT_W, number of tiles folded into the group; saturating.
- `err_op`, out, 1, sticky flag: a non-first tile arrived with `in_op` different from the latched op.

## Operation
- A transfer occurs on a cycle where `in_valid && in_ready`. An output transfer occurs on a cycle where `out_valid && out_ready`.
- State machine:
  - IDLE: accumulator is empty.
    - On a transfer: acc ← `in_tile`, op_q ← `in_op`, cnt ← 1.
    - If `in_last`, go to DONE; otherwise go to ACCUM.
  - ACCUM: on a transfer, for each element (i,j): acc[i][j] ← (op_q==0) ? acc+in (mod 2^W) : max_unsigned(acc, in).
    - cnt ← cnt+1, saturating at 2^CNT_W−1.
    - If `in_last`, go to DONE.
  - DONE: `out_valid`=1, `in_ready`=0. On an output transfer, go to IDLE. There is no bypass, so there is one idle cycle between groups.
- `in_ready` = (state != DONE).
- `out_tile`/`out_op`/`out_count` = acc/op_q/cnt. Their values are meaningful only while `out_valid`.
- Op mismatch: a transfer in ACCUM with `in_op != op_q` still reduces using op_q and sets `err_op`. `err_op` clears only on `rst`.
- The add result is truncated to W bits, with no saturation, consistent with the ETC multiply-accumulate (MMA) path. Max compares unsigned.
- Outputs must hold stable while `out_valid && !out_ready`.

## Timing
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_tile`=0, `out_op`=0, `out_count`=0, `err_op`=0.
- Latency: a transfer with `in_last` at edge t asserts `out_valid` after edge t. The earliest next input transfer is at the edge following the output transfer.
- One tile is accepted per cycle while in IDLE/ACCUM. `in_valid` without `in_ready` has no effect.
- If `rst` is asserted mid-group or in DONE, the group is discarded. All registers take their reset values on that edge, and `rst` overrides any concurrent handshake.
- A single-tile group (first tile has `in_last`=1) produces `out_tile`=`in_tile` and `out_count`=1.
- The counter saturates at 255 (`CNT_W`=8). Accumulation continues past saturation.

## Structure
- Shared package `etc_pkg`:
  - `etc_tile_t` typedef, `[3:0][3:0][W-1:0]`.
  - Op encoding constants: `ETC_OP_MMA=2'd0`; every non-zero value means MAXMUL.
  - State enum `{IDLE, ACCUM, DONE}`.
- One natural sub-module: `etc_elem_reduce`. It is combinational and computes one element's next value from (acc, in, op). Instantiate it 16 times via generate.

## Test plan
- After `rst`, send 3 tiles with `op=0`: all elements 1, then 2, then 3 (3rd with last). Require `out_tile` all 6, `out_count`=3, `out_op`=0, and `out_valid` one cycle after the last accept.
- Send `op=1` with tiles where element [0][0] = 5, 9, 2 and the other elements are 0xFFFF, 0, 7. Require [0][0]=9, the other elements = 0xFFFF, and `out_count`=3.
- Send `op=0` with elements 0xFFFF + 0x0002. Require 0x0001 (wrap).
- Hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`. Require `in_ready`=0, stable outputs, and no tile absorbed. Then raise `out_ready`: IDLE follows, and the next group starts cleanly.
- Second tile carries `op=2` while the latched op is 0. Require add used, `err_op`=1 persisting across later groups until `rst`.
- Assert `rst` mid-group (after 2 of 4 tiles), then send a 1-tile group of value 7. Require `out_tile`=7, `out_count`=1, and `out_valid`=0 during and right after reset.
